nios2_mul_result_combine: RTL and testbench

- Downstream stage of the CPU multiply cell.
- Consumes the three registered 16x16 unsigned partial products available in the M stage:
  - p1 = src1[15:0]*src2[15:0]
  - p2 = src1[15:0]*src2[31:16]
  - p3 = src1[31:16]*src2[15:0]
- Reduces them over two pipelined stages (A, W) into the low 32 bits of src1*src2 (the mul/muli result).
- Carries valid and destination-register tags alongside, so the writeback mux and hazard logic can use the result.

---
 rtl/nios2_mul_result_combine.sv | 116 +++++++++++
 tb/tb_nios2_mul_result_combine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_mul_result_combine.sv
`default_nettype none
// ============================================================================
// Module   : nios2_mul_result_combine
// Purpose  : Back end of the CPU multiply cell. Takes the three 16x16 partial
//            products presented in M and reduces them over two registered
//            stages (A, W) into the low 32 bits of src1*src2. Valid and
//            destination-register tags travel alongside for writeback and
//            hazard detection.
// Ports    : clk, reset_n (async, active low)
//            M_mul_cell_p1/p2/p3   partial products lo*lo, lo*hi, hi*lo
//            M_mul_valid, M_dst_regnum   M-stage instruction tag
//            A_en, W_en            stage advance enables (low = stall)
//            A_pipe_flush, W_pipe_flush  kill the instruction entering A / W
//            A_mul_busy, A_mul_dst_regnum   A-stage occupancy for hazards
//            W_mul_result, W_mul_valid, W_mul_dst_regnum   writeback result
// Revision : 1.0  initial release
// ============================================================================
module nios2_mul_result_combine #(
    parameter int DST_W             = 5,
    parameter bit CLR_DATA_ON_FLUSH = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      M_mul_cell_p1,
    input  logic [31:0]      M_mul_cell_p2,
    input  logic [31:0]      M_mul_cell_p3,
    input  logic             M_mul_valid,
    input  logic [DST_W-1:0] M_dst_regnum,
    input  logic             A_en,
    input  logic             W_en,
    input  logic             A_pipe_flush,
    input  logic             W_pipe_flush,
    output logic             A_mul_busy,
    output logic [DST_W-1:0] A_mul_dst_regnum,
    output logic [31:0]      W_mul_result,
    output logic             W_mul_valid,
    output logic [DST_W-1:0] W_mul_dst_regnum
);

    localparam bit c_clr_on_flush = CLR_DATA_ON_FLUSH;

    // A-stage registers
    logic [31:0]      r_a_p1;
    logic [15:0]      r_a_cross;
    logic             r_a_valid;
    logic [DST_W-1:0] r_a_dst;

    // W-stage registers
    logic [31:0]      r_w_result;
    logic             r_w_valid;
    logic [DST_W-1:0] r_w_dst;

    // Only the low 32 bits of the product are produced, so only the low
    // halves of the cross products can affect the result; their carry out of
    // bit 15 would land above bit 31 and is dropped on purpose.
    logic [15:0] w_a_cross;
    logic [31:0] w_w_result;
    logic        w_unused_hi;

    assign w_a_cross   = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
    assign w_w_result  = r_a_p1 + {r_a_cross, 16'h0000};
    assign w_unused_hi = &{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

    // ------------------------------------------------------------------
    // M -> A
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_p1    <= '0;
            r_a_cross <= '0;
            r_a_valid <= 1'b0;
            r_a_dst   <= '0;
        end else if (A_en) begin
            if (c_clr_on_flush && A_pipe_flush) begin
                r_a_p1    <= '0;
                r_a_cross <= '0;
                r_a_dst   <= '0;
            end else begin
                r_a_p1    <= M_mul_cell_p1;
                r_a_cross <= w_a_cross;
                r_a_dst   <= M_dst_regnum;
            end
            r_a_valid <= M_mul_valid & ~A_pipe_flush;
        end
    end

    // ------------------------------------------------------------------
    // A -> W. W always samples the pre-edge A contents, so a simultaneous
    // M->A shift never leaks into W on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_w_result <= '0;
            r_w_valid  <= 1'b0;
            r_w_dst    <= '0;
        end else if (W_en) begin
            if (c_clr_on_flush && W_pipe_flush) begin
                r_w_result <= '0;
                r_w_dst    <= '0;
            end else begin
                r_w_result <= w_w_result;
                r_w_dst    <= r_a_dst;
            end
            r_w_valid <= r_a_valid & ~W_pipe_flush;
        end
    end

    // All outputs come straight from registers.
    assign A_mul_busy       = r_a_valid;
    assign A_mul_dst_regnum = r_a_dst;
    assign W_mul_result     = r_w_result;
    assign W_mul_valid      = r_w_valid;
    assign W_mul_dst_regnum = r_w_dst;

endmodule
`default_nettype wire

// File: tb/tb_nios2_mul_result_combine.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_mul_result_combine
// Purpose  : Self-checking bench for nios2_mul_result_combine: directed
//            vector table, hand-written stall/flush/reset sequences, and a
//            randomized run against a transaction-level pipeline model whose
//            expected result is simply the low 32 bits of src1*src2.
// Revision : 1.0  initial release
// ============================================================================
module tb_nios2_mul_result_combine;

    localparam int DST_W = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [31:0]      p1, p2, p3;
    logic             m_valid;
    logic [DST_W-1:0] m_dst;
    logic             a_en, w_en, a_fl, w_fl;
    logic             a_busy;
    logic [DST_W-1:0] a_dst;
    logic [31:0]      w_result;
    logic             w_valid;
    logic [DST_W-1:0] w_dst;

    int n_cmp = 0;
    int n_bad = 0;

    nios2_mul_result_combine #(.DST_W(DST_W), .CLR_DATA_ON_FLUSH(1'b0)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .M_mul_cell_p1    (p1),
        .M_mul_cell_p2    (p2),
        .M_mul_cell_p3    (p3),
        .M_mul_valid      (m_valid),
        .M_dst_regnum     (m_dst),
        .A_en             (a_en),
        .W_en             (w_en),
        .A_pipe_flush     (a_fl),
        .W_pipe_flush     (w_fl),
        .A_mul_busy       (a_busy),
        .A_mul_dst_regnum (a_dst),
        .W_mul_result     (w_result),
        .W_mul_valid      (w_valid),
        .W_mul_dst_regnum (w_dst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] prod(input logic [31:0] s1, input logic [31:0] s2);
        return s1 * s2;
    endfunction

    // Present the M-stage partial products that the multiply cell would
    // produce for operands s1, s2.
    task automatic set_m(input logic [31:0] s1, input logic [31:0] s2,
                         input logic v, input logic [DST_W-1:0] d);
        p1      = {16'h0, s1[15:0]}  * {16'h0, s2[15:0]};
        p2      = {16'h0, s1[15:0]}  * {16'h0, s2[31:16]};
        p3      = {16'h0, s1[31:16]} * {16'h0, s2[15:0]};
        m_valid = v;
        m_dst   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_busy"}, {31'h0, a_busy}, 32'h0);
        chk({tag, "_a_dst"},  {27'h0, a_dst},  32'h0);
        chk({tag, "_w_res"},  w_result,        32'h0);
        chk({tag, "_w_valid"},{31'h0, w_valid},32'h0);
        chk({tag, "_w_dst"},  {27'h0, w_dst},  32'h0);
    endtask

    typedef struct {
        logic [31:0]      s1;
        logic [31:0]      s2;
        logic [DST_W-1:0] dst;
        logic [31:0]      exp;
    } vec_t;

    vec_t vecs[6];

    // Transaction-level model state for the random phase
    logic             ma_v, mw_v, consumed;
    logic [DST_W-1:0] ma_dst, mw_dst;
    logic [31:0]      ma_res, mw_res;

    initial begin
        logic [31:0] r1, r2, w_hold;
        logic [DST_W-1:0] dh;

        vecs[0] = '{32'h0003_0002, 32'h0005_0004, 5'd4,  32'h0016_0008};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
        vecs[2] = '{32'h0001_0001, 32'h0001_0001, 5'd9,  32'h0002_0001};
        vecs[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 5'd17, 32'h242D_2080};
        vecs[4] = '{32'h0000_0007, 32'h0000_0006, 5'd1,  32'h0000_002A};
        vecs[5] = '{32'h0001_0000, 32'h0001_0000, 5'd22, 32'h0000_0000};

        set_m('0, '0, 1'b0, '0);
        a_en = 1'b0; w_en = 1'b0; a_fl = 1'b0; w_fl = 1'b0;

        // ---------------- reset ----------------
        #2;
        chk_all_zero("reset");
        a_en = 1'b1; w_en = 1'b1;
        set_m(32'h5, 32'h7, 1'b1, 5'd3);
        tick();
        chk_all_zero("reset_held");
        #3 reset_n = 1'b1;
        set_m('0, '0, 1'b0, '0);
        tick();
        tick();

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 6; i++) begin
            set_m(vecs[i].s1, vecs[i].s2, 1'b1, vecs[i].dst);
            tick();
            chk("vec_a_busy", {31'h0, a_busy}, 32'h1);
            chk("vec_a_dst",  {27'h0, a_dst},  {27'h0, vecs[i].dst});
            set_m('0, '0, 1'b0, '0);
            tick();
            chk("vec_w_res",   w_result,         vecs[i].exp);
            chk("vec_w_valid", {31'h0, w_valid}, 32'h1);
            chk("vec_w_dst",   {27'h0, w_dst},   {27'h0, vecs[i].dst});
        end
        tick();

        // ---------------- stall W for 3 cycles ----------------
        set_m(32'h0001_0001, 32'h0001_0001, 1'b1, 5'd12);
        a_en = 1'b1; w_en = 1'b0;
        tick();
        chk("stall_a_busy", {31'h0, a_busy}, 32'h1);
        w_hold = w_result; dh = w_dst;
        a_en = 1'b0;
        set_m('0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_w_res_hold", w_result, w_hold);
            chk("stall_w_dst_hold", {27'h0, w_dst}, {27'h0, dh});
            chk("stall_w_valid_hold", {31'h0, w_valid}, 32'h0);
        end
        w_en = 1'b1;
        tick();
        chk("stall_w_res",   w_result,         32'h0002_0001);
        chk("stall_w_valid", {31'h0, w_valid}, 32'h1);
        chk("stall_w_dst",   {27'h0, w_dst},   32'd12);
        // A still holds the consumed instruction: refill it before W moves again
        w_en = 1'b0; a_en = 1'b1;
        tick();
        w_en = 1'b1;

        // ---------------- flush with A_en=1 ----------------
        set_m(32'h3, 32'h3, 1'b1, 5'd7);
        a_fl = 1'b1;
        tick();
        chk("flush_a_busy", {31'h0, a_busy}, 32'h0);
        a_fl = 1'b0;
        set_m('0, '0, 1'b0, '0);
        tick();
        chk("flush_w_valid", {31'h0, w_valid}, 32'h0);

        // ---------------- flush with A_en=0 has no effect ----------------
        set_m(32'h4, 32'h5, 1'b1, 5'd8);
        w_en = 1'b0;
        tick();
        a_en = 1'b0; a_fl = 1'b1;
        set_m('0, '0, 1'b0, '0);
        tick();
        chk("noflush_a_busy", {31'h0, a_busy}, 32'h1);
        a_fl = 1'b0; a_en = 1'b1; w_en = 1'b1;
        tick();
        chk("noflush_w_valid", {31'h0, w_valid}, 32'h1);
        chk("noflush_w_res",   w_result,         32'd20);

        // ---------------- W flush ----------------
        set_m(32'h9, 32'h9, 1'b1, 5'd5);
        tick();
        w_fl = 1'b1;
        set_m('0, '0, 1'b0, '0);
        tick();
        chk("wflush_w_valid", {31'h0, w_valid}, 32'h0);
        w_fl = 1'b0;

        // ---------------- back-to-back ----------------
        set_m(32'h0000_1111, 32'h0002_0003, 1'b1, 5'd1);
        tick();
        set_m(32'hABCD_0123, 32'h0000_FFFF, 1'b1, 5'd2);
        tick();
        chk("b2b_dst1", {27'h0, w_dst}, 32'd1);
        chk("b2b_res1", w_result, prod(32'h0000_1111, 32'h0002_0003));
        chk("b2b_v1",   {31'h0, w_valid}, 32'h1);
        set_m(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 5'd3);
        tick();
        chk("b2b_dst2", {27'h0, w_dst}, 32'd2);
        chk("b2b_res2", w_result, prod(32'hABCD_0123, 32'h0000_FFFF));
        chk("b2b_v2",   {31'h0, w_valid}, 32'h1);
        set_m(32'h0000_0002, 32'h0000_0003, 1'b1, 5'd4);
        tick();
        chk("b2b_dst3", {27'h0, w_dst}, 32'd3);
        chk("b2b_res3", w_result, prod(32'hDEAD_BEEF, 32'hCAFE_F00D));
        chk("b2b_v3",   {31'h0, w_valid}, 32'h1);
        set_m(32'h0000_0005, 32'h0000_0006, 1'b1, 5'd6);
        tick();
        // A and W both valid here: reset mid-stream
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        a_en = 1'b0; w_en = 1'b0;
        #3 reset_n = 1'b1;
        tick();
        tick();
        chk_all_zero("post_rst");

        // ---------------- randomized vs model ----------------
        ma_v = 1'b0; ma_dst = '0; ma_res = '0;
        mw_v = 1'b0; mw_dst = '0; mw_res = '0;
        consumed = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            r2 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            dh = DST_W'($urandom);
            set_m(r1, r2, 1'($urandom_range(0, 3) != 0), dh);
            a_en = ($urandom_range(0, 3) != 0);
            w_en = ($urandom_range(0, 3) != 0);
            a_fl = ($urandom_range(0, 5) == 0);
            w_fl = ($urandom_range(0, 5) == 0);
            if (consumed && !a_en) w_en = 1'b0;
            if (w_en) begin
                mw_v = ma_v & ~w_fl; mw_dst = ma_dst; mw_res = ma_res;
                consumed = 1'b1;
            end
            if (a_en) begin
                ma_v = m_valid & ~a_fl; ma_dst = dh; ma_res = prod(r1, r2);
                consumed = 1'b0;
            end
            tick();
            chk("rnd_a_busy",  {31'h0, a_busy},  {31'h0, ma_v});
            chk("rnd_a_dst",   {27'h0, a_dst},   {27'h0, ma_dst});
            chk("rnd_w_valid", {31'h0, w_valid}, {31'h0, mw_v});
            chk("rnd_w_dst",   {27'h0, w_dst},   {27'h0, mw_dst});
            chk("rnd_w_res",   w_result,         mw_res);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
